lsd_buffer_reader: RTL and testbench

- Readout sequencer for the write-protected LSD segment buffer.
- Waits for a completed frame of segments and asserts write-protect so the buffer freezes.
- Walks read addresses 0..line_num-1, absorbing the buffer's read latency, and emits each segment as a valid/ready stream beat to the downstream consumer (CPU register bridge / DMA packer).
- Releases write-protect when the walk is done.
- Sits between the segment output buffer and the PS-side readout logic.

---
 rtl/lsd_buffer_reader_if.sv | 35 +++
 rtl/lsd_buffer_reader.sv | 249 ++++++++++++++++++++++++
 tb/tb_lsd_buffer_reader.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lsd_buffer_reader_if.sv
// Segment beat stream from the LSD buffer reader to the PS-side consumer.
//
// Signals:
//   m_valid            beat valid (source)
//   m_ready            consumer accepts beat (sink)
//   m_start_v, m_end_v segment vertical extent
//   m_start_h, m_end_h segment horizontal extent
//   m_index            segment index within the frame
//   m_last             final beat of the frame
//
// Modports: master (reader side), slave (consumer side).
interface lsd_buffer_reader_if #(
    parameter int unsigned VW = 10,
    parameter int unsigned HW = 10,
    parameter int unsigned AW = 12
);
    logic          m_valid;
    logic          m_ready;
    logic [VW-1:0] m_start_v;
    logic [VW-1:0] m_end_v;
    logic [HW-1:0] m_start_h;
    logic [HW-1:0] m_end_h;
    logic [AW-1:0] m_index;
    logic          m_last;

    modport master (
        output m_valid, m_start_v, m_end_v, m_start_h, m_end_h, m_index, m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid, m_start_v, m_end_v, m_start_h, m_end_h, m_index, m_last,
        output m_ready
    );
endinterface

// File: rtl/lsd_buffer_reader.sv
// Readout sequencer for the write-protected LSD segment buffer.
//
// Waits for a completed frame, write-protects the buffer, walks read addresses
// 0..N-1 absorbing the buffer read latency, and emits each segment as a
// valid/ready beat. Write-protect is released when the walk ends or is aborted.
//
// Ports:
//   clk, rst            pixel clock, synchronous active-high reset
//   start, abort        one-cycle readout request / early termination
//   buf_ready           buffer holds a completed frame
//   buf_line_num        number of valid segments in the buffer
//   buf_start_v..end_h  buffer read data (RD_LATENCY cycles after buf_addr)
//   buf_addr            buffer read address
//   buf_write_protect   freezes buffer contents while reading
//   m                   segment beat stream (lsd_buffer_reader_if.master)
//   busy                readout in progress
//   done                one-cycle pulse at readout end
//   done_count          beats transferred in the last readout
//
// Optional build macro: LSD_BUFFER_READER_AUTO_EN -- a rising edge of buf_ready
// queues a readout automatically, so every new frame is read out without start.
module lsd_buffer_reader #(
    parameter int unsigned V_FRAME    = 525,
    parameter int unsigned H_FRAME    = 800,
    parameter int unsigned RAM_SIZE   = 4096,
    parameter int unsigned RD_LATENCY = 1,
    localparam int unsigned VW = $clog2(V_FRAME),
    localparam int unsigned HW = $clog2(H_FRAME),
    localparam int unsigned AW = $clog2(RAM_SIZE)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          buf_ready,
    input  logic [AW-1:0] buf_line_num,
    input  logic [VW-1:0] buf_start_v,
    input  logic [VW-1:0] buf_end_v,
    input  logic [HW-1:0] buf_start_h,
    input  logic [HW-1:0] buf_end_h,
    output logic [AW-1:0] buf_addr,
    output logic          buf_write_protect,
    lsd_buffer_reader_if.master m,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] done_count
);

    typedef enum logic [2:0] {
        StIdle,
        StLock,
        StWait,
        StHold,
        StRelease
    } state_t;

    state_t        state_q, state_d;
    logic          pending_q, pending_d;
    logic          lock_wait_q, lock_wait_d;
    logic [2:0]    lat_cnt_q, lat_cnt_d;
    logic [AW-1:0] n_q, n_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] beat_q, beat_d;
    logic          wp_q, wp_d;
    logic          valid_q, valid_d;
    logic [VW-1:0] start_v_q, start_v_d, end_v_q, end_v_d;
    logic [HW-1:0] start_h_q, start_h_d, end_h_q, end_h_d;
    logic [AW-1:0] index_q, index_d;
    logic          last_q, last_d;
    logic          done_q, done_d;
    logic [AW-1:0] done_count_q, done_count_d;

    logic req;
    logic handshake;

`ifdef LSD_BUFFER_READER_AUTO_EN
    logic buf_ready_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_ready_q <= 1'b0;
        end else begin
            buf_ready_q <= buf_ready;
        end
    end

    // A new frame arriving acts like a start request.
    assign req = start | (buf_ready & ~buf_ready_q);
`else
    assign req = start;
`endif

    assign handshake = valid_q & m.m_ready;

    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        lock_wait_d  = lock_wait_q;
        lat_cnt_d    = lat_cnt_q;
        n_d          = n_q;
        addr_d       = addr_q;
        beat_d       = beat_q;
        wp_d         = wp_q;
        valid_d      = valid_q;
        start_v_d    = start_v_q;
        end_v_d      = end_v_q;
        start_h_d    = start_h_q;
        end_h_d      = end_h_q;
        index_d      = index_q;
        last_d       = last_q;
        done_d       = 1'b0;
        done_count_d = done_count_q;

        // Requests that cannot be served immediately are queued (one deep).
        if (req && !(state_q == StIdle && buf_ready)) begin
            pending_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (abort) begin
                    pending_d = 1'b0;
                end
                if ((req || (pending_q && !abort)) && buf_ready) begin
                    state_d     = StLock;
                    pending_d   = 1'b0;
                    wp_d        = 1'b1;
                    lock_wait_d = 1'b1;
                    beat_d      = '0;
                end
            end
            StLock: begin
                if (abort) begin
                    state_d = StRelease;
                end else if (lock_wait_q) begin
                    // Give the freeze one cycle to settle before sampling the count.
                    lock_wait_d = 1'b0;
                end else begin
                    n_d = buf_line_num;
                    if (buf_line_num == '0) begin
                        state_d = StRelease;
                    end else begin
                        addr_d    = '0;
                        lat_cnt_d = '0;
                        state_d   = StWait;
                    end
                end
            end
            StWait: begin
                if (abort) begin
                    state_d = StRelease;
                end else if (lat_cnt_q == 3'(RD_LATENCY)) begin
                    start_v_d = buf_start_v;
                    end_v_d   = buf_end_v;
                    start_h_d = buf_start_h;
                    end_h_d   = buf_end_h;
                    index_d   = addr_q;
                    last_d    = (addr_q == n_q - AW'(1));
                    valid_d   = 1'b1;
                    state_d   = StHold;
                end else begin
                    lat_cnt_d = lat_cnt_q + 3'd1;
                end
            end
            StHold: begin
                if (handshake) begin
                    beat_d = beat_q + AW'(1);
                end
                if (abort || (handshake && last_q)) begin
                    state_d = StRelease;
                end else if (handshake) begin
                    valid_d   = 1'b0;
                    addr_d    = addr_q + AW'(1);
                    lat_cnt_d = '0;
                    state_d   = StWait;
                end
            end
            StRelease: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Entry into release: drop protect and valid, publish the count with done.
        if (state_d == StRelease && state_q != StRelease) begin
            wp_d         = 1'b0;
            valid_d      = 1'b0;
            done_d       = 1'b1;
            done_count_d = beat_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            pending_q    <= 1'b0;
            lock_wait_q  <= 1'b0;
            lat_cnt_q    <= '0;
            n_q          <= '0;
            addr_q       <= '0;
            beat_q       <= '0;
            wp_q         <= 1'b0;
            valid_q      <= 1'b0;
            start_v_q    <= '0;
            end_v_q      <= '0;
            start_h_q    <= '0;
            end_h_q      <= '0;
            index_q      <= '0;
            last_q       <= 1'b0;
            done_q       <= 1'b0;
            done_count_q <= '0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            lock_wait_q  <= lock_wait_d;
            lat_cnt_q    <= lat_cnt_d;
            n_q          <= n_d;
            addr_q       <= addr_d;
            beat_q       <= beat_d;
            wp_q         <= wp_d;
            valid_q      <= valid_d;
            start_v_q    <= start_v_d;
            end_v_q      <= end_v_d;
            start_h_q    <= start_h_d;
            end_h_q      <= end_h_d;
            index_q      <= index_d;
            last_q       <= last_d;
            done_q       <= done_d;
            done_count_q <= done_count_d;
        end
    end

    assign buf_addr          = addr_q;
    assign buf_write_protect = wp_q;
    assign busy              = (state_q != StIdle);
    assign done              = done_q;
    assign done_count        = done_count_q;

    assign m.m_valid   = valid_q;
    assign m.m_start_v = start_v_q;
    assign m.m_end_v   = end_v_q;
    assign m.m_start_h = start_h_q;
    assign m.m_end_h   = end_h_q;
    assign m.m_index   = index_q;
    assign m.m_last    = last_q;

endmodule

// File: tb/tb_lsd_buffer_reader.sv
// Self-checking bench for lsd_buffer_reader (default build, RD_LATENCY = 1).
// A registered-read buffer model feeds random segment data; every accepted
// beat is compared against the segment list the buffer holds.
module tb_lsd_buffer_reader;
    localparam int unsigned VW         = 10;
    localparam int unsigned HW         = 10;
    localparam int unsigned AW         = 12;
    localparam int unsigned RD_LATENCY = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic          buf_ready;
    logic [AW-1:0] buf_line_num;
    logic [VW-1:0] buf_start_v, buf_end_v;
    logic [HW-1:0] buf_start_h, buf_end_h;
    logic [AW-1:0] buf_addr;
    logic          buf_write_protect;
    logic          busy;
    logic          done;
    logic [AW-1:0] done_count;

    lsd_buffer_reader_if #(.VW(VW), .HW(HW), .AW(AW)) m_if ();

    lsd_buffer_reader #(
        .V_FRAME   (525),
        .H_FRAME   (800),
        .RAM_SIZE  (4096),
        .RD_LATENCY(RD_LATENCY)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .abort            (abort),
        .buf_ready        (buf_ready),
        .buf_line_num     (buf_line_num),
        .buf_start_v      (buf_start_v),
        .buf_end_v        (buf_end_v),
        .buf_start_h      (buf_start_h),
        .buf_end_h        (buf_end_h),
        .buf_addr         (buf_addr),
        .buf_write_protect(buf_write_protect),
        .m                (m_if),
        .busy             (busy),
        .done             (done),
        .done_count       (done_count)
    );

    always #5 clk = ~clk;

    // Buffer contents {start_v, end_v, start_h, end_h}, registered read.
    logic [39:0] mem [64];
    logic [39:0] rd_pipe [RD_LATENCY];

    always @(posedge clk) begin
        rd_pipe[0] <= mem[buf_addr[5:0]];
        for (int i = 1; i < RD_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    assign {buf_start_v, buf_end_v, buf_start_h, buf_end_h} = rd_pipe[RD_LATENCY-1];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] beat_exp(input int k, input int n);
        return {11'b0, 12'(k), (k == n - 1), mem[k]};
    endfunction

    function automatic logic [63:0] beat_obs();
        return {11'b0, m_if.m_index, m_if.m_last, m_if.m_start_v, m_if.m_end_v,
                m_if.m_start_h, m_if.m_end_h};
    endfunction

    task automatic load(input int n);
        buf_line_num = AW'(n);
        for (int i = 0; i < 64; i++) mem[i] = 40'({$urandom, $urandom});
    endtask

    // mode 0: plain start, 1: start before buf_ready, 2: request already queued
    task automatic kick(input int mode);
        if (mode == 0) begin
            buf_ready = 1'b1;
            start = 1'b1;
            tick();
            start = 1'b0;
            check("wp_rise", buf_write_protect, 1);
        end else if (mode == 1) begin
            buf_ready = 1'b0;
            start = 1'b1;
            tick();
            start = 1'b0;
            repeat (10) tick();
            check("pend_idle", {busy, buf_write_protect}, 0);
            buf_ready = 1'b1;
            tick();
            check("pend_lock", buf_write_protect, 1);
        end else begin
            tick();
            check("queued_lock", buf_write_protect, 1);
        end
    endtask

    // rmode 0: always ready, 1: random ready, 2: stall beat 1 for 5 cycles
    task automatic watch(input int n, input int rmode, input int abort_beat, input bit queue);
        int k = 0;
        int wp_cyc = 0;
        int stall = 5;
        int exp_beats;
        bit after_abort = 0;
        bit queued = 0;
        bit finished = 0;
        exp_beats = (abort_beat >= 0) ? abort_beat : n;
        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            start = 1'b0;
            abort = 1'b0;
            if (after_abort) begin
                check("abort_drop", m_if.m_valid, 0);
                after_abort = 0;
            end
            if (done) begin
                check("done_count", done_count, exp_beats);
                check("beats", k, exp_beats);
                check("wp_release", buf_write_protect, 0);
                if (rmode == 0 && abort_beat < 0)
                    check("wp_cycles", wp_cyc, (n == 0) ? 2 : 2 + n * (RD_LATENCY + 2));
                m_if.m_ready = 1'b0;
                tick();
                check("done_pulse", {done, busy}, 0);
                finished = 1;
            end else begin
                if (buf_write_protect) wp_cyc++;
                if (m_if.m_valid) begin
                    if (k >= n) check("extra_beat", m_if.m_valid, 0);
                    else check("beat", beat_obs(), beat_exp(k, n));
                    check("hold_addr", buf_addr, k);
                    check("hold_wp", buf_write_protect, 1);
                    if (k == abort_beat) begin
                        m_if.m_ready = 1'b0;
                        abort = 1'b1;
                        after_abort = 1;
                    end else if (rmode == 2 && k == 1 && stall > 0) begin
                        m_if.m_ready = 1'b0;
                        stall--;
                    end else if (rmode == 1) begin
                        m_if.m_ready = 1'($urandom_range(0, 1));
                    end else begin
                        m_if.m_ready = 1'b1;
                    end
                    if (queue && !queued) begin
                        start = 1'b1;
                        queued = 1;
                    end
                    if (m_if.m_ready) k++;
                end else begin
                    m_if.m_ready = (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                tick();
            end
        end
        if (!finished) check("timeout", 1, 0);
    endtask

    initial begin
        int k;
        bool_reached: begin end
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        buf_ready = 1'b0;
        buf_line_num = '0;
        m_if.m_ready = 1'b0;
        load(0);
        repeat (3) tick();
        check("reset_outs", {beat_obs(), buf_addr, buf_write_protect, m_if.m_valid,
                             busy, done, done_count}, 0);
        rst = 1'b0;
        tick();

        // Basic, empty, backpressure, pending, abort
        load(3); kick(0); watch(3, 0, -1, 0);
        load(0); kick(0); watch(0, 0, -1, 0);
        load(4); kick(0); watch(4, 2, -1, 0);
        load(2); kick(1); watch(2, 0, -1, 0);
        load(8); kick(0); watch(8, 0, 3, 0);

        // Abort in IDLE discards a pending request
        buf_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        buf_ready = 1'b1;
        repeat (3) tick();
        check("idle_abort", busy, 0);

        // Start during readout is queued and runs after done
        load(3); kick(0); watch(3, 1, -1, 1);
        kick(2); watch(3, 0, -1, 0);

        // Reset during WAIT of beat 2
        load(6); kick(0);
        k = 0;
        m_if.m_ready = 1'b1;
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (m_if.m_valid) k++;
            else if (k == 2) break;
            tick();
        end
        check("rst_at_beat2", {k[7:0], buf_addr}, {8'd2, 12'd2});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_outs", {beat_obs(), buf_addr, buf_write_protect, m_if.m_valid,
                               busy, done, done_count}, 0);
        kick(0); watch(6, 0, -1, 0);

        // Random frames with random backpressure
        for (int r = 0; r < 4; r++) begin
            int n;
            n = $urandom_range(1, 12);
            load(n); kick(0); watch(n, 1, -1, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
